// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder. Captures a, b and carry-in on start, then
//                adds one bit per clock (LSB first) over WIDTH cycles and
//                presents the registered sum / carry-out with a one-cycle
//                done pulse. Optional signed-overflow output is compiled in
//                when the macro SERIAL_ADDER_OVF_EN is defined.
//  Ports       : clk   - clock, rising edge
//                rst   - synchronous active-high reset
//                start - begin an addition (sampled only while ready=1)
//                a, b  - WIDTH-bit operands, c - carry-in
//                ready - high in IDLE (start will be accepted)
//                done  - one-cycle pulse, s/co hold a new result
//                s, co - registered sum and carry-out
//                ovf   - registered signed overflow (SERIAL_ADDER_OVF_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_s;
    logic               r_co;

    logic               w_sum_bit;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;

    // One full-adder slice; operands are shifted right so bit 0 is always
    // the bit under process, and sum bits enter the accumulator at the MSB
    // so after WIDTH shifts the accumulator is aligned.
    assign w_sum_bit    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_acc_next   = {w_sum_bit, r_acc[WIDTH-1:1]};
    assign w_last       = (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_carry_next;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    // Results are published only on the DONE-entry edge so
                    // s/co stay stable through later operations.
                    if (w_last) begin
                        r_s  <= w_acc_next;
                        r_co <= w_carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last RUN edge r_carry is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= r_carry ^ w_carry_next;
        end
    end

    assign ovf = r_ovf;
`endif

    assign ready = (r_state == S_IDLE);
    assign done  = (r_state == S_DONE);
    assign s     = r_s;
    assign co    = r_co;

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin an addition; sampled only while ready=1.
REQ-005 The block SHALL have port a  input  WIDTH  first operand; captured on the start acceptance edge.
REQ-006 The block SHALL have port b  input  WIDTH  second operand; captured on the start acceptance edge.
REQ-007 The block SHALL have port c  input  1  carry-in; captured on the start acceptance edge.
REQ-008 The block SHALL have port ready  output  1  high only in IDLE, meaning start will be accepted.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking that s/co hold a new result.
REQ-010 The block SHALL have port s  output  WIDTH  registered sum.
REQ-011 The block SHALL have port co  output  1  registered carry-out.
REQ-012 The block SHALL have port ovf  output  1  registered signed overflow; present only with the Configuration macro.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the rising edge SHALL capture a, b and c into internal registers, clear the bit counter and enter RUN (the acceptance edge E0).
REQ-015 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-016 In RUN, each rising edge SHALL process exactly one bit, LSB first: sum bit = a[i]^b[i]^carry; carry = majority(a[i],b[i],carry); the sum bit shifts into the result register; the counter increments.
REQ-017 The counter SHALL be $clog2(WIDTH)+1 bits wide, and RUN SHALL last exactly WIDTH cycles, edges E1..E_WIDTH.
REQ-018 At E_WIDTH the FSM SHALL enter DONE and load the final sum into s and the final carry into co.
REQ-019 done SHALL be 1 only in DONE, i.e. exactly WIDTH cycles after E0, for exactly one cycle.
REQ-020 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-021 Per-operation occupancy SHALL be WIDTH+1 cycles; back-to-back starts (start held high) SHALL yield one result every WIDTH+2 cycles.
REQ-022 s, co and ovf SHALL change only at the DONE-entry edge or on reset, holding their value otherwise, including through later RUN phases.
REQ-023 Changes on a, b or c after E0 SHALL NOT affect the result in progress.
REQ-024 start in RUN or DONE SHALL be ignored, neither queued nor restarting.
REQ-025 The result SHALL equal (a+b+c) mod 2^WIDTH, with co = bit WIDTH of the full sum.

Reset
REQ-026 With rst=1 at a rising edge, the FSM SHALL go to IDLE and s, co, ovf, done, the counter, the carry and the operand registers SHALL all be 0; ready SHALL be 1 in the following cycle.
REQ-027 rst SHALL take priority over start and over all FSM transitions.
REQ-028 rst during RUN or DONE SHALL abort the operation with no done pulse, and the aborted result SHALL be lost.

Configuration
REQ-029 The macro SERIAL_ADDER_OVF_EN SHALL control the overflow feature.
REQ-030 With SERIAL_ADDER_OVF_EN defined, port ovf and its register SHALL exist, and ovf SHALL be loaded at the DONE-entry edge with (carry into MSB) XOR co.
REQ-031 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 WIDTH=8, a=8'h00, b=8'h00, c=1, start one cycle -> done high exactly 8 cycles after E0 for 1 cycle; s=8'h01, co=0.
REQ-033 WIDTH=8, a=8'hFF, b=8'h01, c=0 -> s=8'h00, co=1, ovf=0; then a=8'h7F, b=8'h01, c=0 -> s=8'h80, co=0, ovf=1 (macro defined).
REQ-034 WIDTH=8, start with a=8'h12, b=8'h34, then start=1 with a=8'hFF, b=8'hFF during RUN -> single done, s=8'h46; second request not executed; ready=0 throughout.
REQ-035 WIDTH=8, rst pulsed on the 4th RUN edge -> next cycle s=0, co=0, done=0, ready=1; no done pulse within the following 10 cycles.
REQ-036 WIDTH=2, all 32 combinations of a, b and c applied back-to-back with start held high -> each done carries {co,s}=a+b+c, with results spaced 4 cycles apart.
REQ-037 WIDTH=8, operands changed on the cycle after E0 -> result reflects the captured values; s/co hold the previous result until the new done.
